// File: rtl/opcode_sequencer.sv
// Decode-stage opcode sequencer: passes fetched opcodes through, expands CALL/RET/RTI
// into two-part pairs and injects interrupt pseudo-opcode pairs at instruction boundaries.
module opcode_sequencer #(
  parameter logic [4:0] INT_OP1 = 5'b11110,
  parameter logic [4:0] INT_OP2 = 5'b11111
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] instr_op,
  input  logic       instr_valid,
  input  logic       stall,
  input  logic       flush,
  input  logic       interrupt_req,
  output logic [4:0] op_out,
  output logic       fetch_hold,
  output logic       int_ack,
  output logic       busy
);

  typedef enum logic [1:0] {StIdle, StSecond, StInt1, StInt2} state_e;

  state_e     state_q, state_d;
  logic       pend_q, pend_d;
  logic [4:0] second_q, second_d;
  logic       take_int;
  logic       is_two_part;
  logic       is_illegal;

  always_comb begin
    is_two_part = (instr_op == 5'b11000) || (instr_op == 5'b11010) || (instr_op == 5'b11100);
    // Second halves and interrupt pseudo-opcodes may only be generated internally.
    is_illegal  = (instr_op == 5'b11001) || (instr_op == 5'b11011) || (instr_op == 5'b11101) ||
                  (instr_op == 5'b11110) || (instr_op == 5'b11111);
  end

  always_comb begin
    state_d    = state_q;
    second_d   = second_q;
    op_out     = 5'b00000;
    fetch_hold = 1'b0;
    int_ack    = 1'b0;
    busy       = (state_q != StIdle);
    take_int   = 1'b0;

    if (!rst) begin
      busy = 1'b0;
    end else if (flush && (state_q == StIdle || state_q == StSecond)) begin
      state_d = StIdle;
    end else if (!stall) begin
      unique case (state_q)
        StIdle: begin
          if (pend_q) begin
            op_out     = INT_OP1;
            fetch_hold = 1'b1;
            state_d    = StInt1;
            take_int   = 1'b1;
          end else if (instr_valid) begin
            if (is_two_part) begin
              op_out     = instr_op;
              fetch_hold = 1'b1;
              state_d    = StSecond;
              second_d   = instr_op | 5'b00001;
            end else if (!is_illegal) begin
              op_out = instr_op;
            end
          end
        end
        StSecond: begin
          op_out  = second_q;
          state_d = StIdle;
        end
        StInt1: begin
          op_out     = INT_OP2;
          fetch_hold = 1'b1;
          int_ack    = 1'b1;
          state_d    = StInt2;
        end
        StInt2: begin
          state_d = StIdle;
        end
      endcase
    end

    // A request in the same cycle the pending flag is consumed re-arms it.
    pend_d = interrupt_req | (pend_q & ~take_int);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      pend_q   <= 1'b0;
      second_q <= 5'b00000;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      second_q <= second_d;
    end
  end

endmodule

// File: tb/tb_opcode_sequencer.sv
// Scoreboarded bench for opcode_sequencer: a queue-of-remaining-parts reference model
// predicts each cycle's outputs; a negedge monitor compares them against the DUT.
module tb_opcode_sequencer;

  localparam logic [4:0] IOP1 = 5'b11110;
  localparam logic [4:0] IOP2 = 5'b11111;
  localparam logic [4:0] ADD  = 5'b01001;

  logic       clk = 1'b0;
  logic       rst, instr_valid, stall, flush, interrupt_req;
  logic [4:0] instr_op;
  logic [4:0] op_out;
  logic       fetch_hold, int_ack, busy;

  int total = 0;
  int bad   = 0;

  opcode_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .instr_op     (instr_op),
    .instr_valid  (instr_valid),
    .stall        (stall),
    .flush        (flush),
    .interrupt_req(interrupt_req),
    .op_out       (op_out),
    .fetch_hold   (fetch_hold),
    .int_ack      (int_ack),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] op;
    logic       hold;
    logic       ack;
    logic       busy;
    string      tag;
  } exp_t;

  typedef struct {
    logic [4:0] op;
    logic       hold;
    logic       ack;
    bit         is_int;
  } part_t;

  exp_t  sb[$];
  part_t rem[$];   // parts still owed to the control unit
  bit    m_pend;

  function automatic bit two_part(input logic [4:0] op);
    return op inside {5'b11000, 5'b11010, 5'b11100};
  endfunction

  function automatic bit illegal(input logic [4:0] op);
    return op inside {5'b11001, 5'b11011, 5'b11101, 5'b11110, 5'b11111};
  endfunction

  // Reference model: advance one cycle, return the expected outputs for it.
  task automatic model_step(input string tag);
    exp_t  e;
    part_t p;
    bit    took;
    e.op = 5'b0; e.hold = 1'b0; e.ack = 1'b0; e.tag = tag;
    e.busy = (rem.size() != 0);
    took = 1'b0;
    if (!rst) begin
      e.busy = 1'b0;
      rem.delete();
      m_pend = 1'b0;
    end else begin
      if (rem.size() != 0 && rem[0].is_int) begin
        if (!stall) begin
          p = rem.pop_front();
          e.op = p.op; e.hold = p.hold; e.ack = p.ack;
        end
      end else if (flush) begin
        rem.delete();
      end else if (stall) begin
        // frozen
      end else if (rem.size() != 0) begin
        p = rem.pop_front();
        e.op = p.op; e.hold = p.hold; e.ack = p.ack;
      end else if (m_pend) begin
        e.op = IOP1; e.hold = 1'b1; took = 1'b1;
        rem.push_back('{op: IOP2, hold: 1'b1, ack: 1'b1, is_int: 1'b1});
        rem.push_back('{op: 5'b0, hold: 1'b0, ack: 1'b0, is_int: 1'b1});
      end else if (instr_valid) begin
        if (two_part(instr_op)) begin
          e.op = instr_op; e.hold = 1'b1;
          rem.push_back('{op: instr_op | 5'b00001, hold: 1'b0, ack: 1'b0, is_int: 1'b0});
        end else if (!illegal(instr_op)) begin
          e.op = instr_op;
        end
      end
      m_pend = interrupt_req || (m_pend && !took);
    end
    sb.push_back(e);
  endtask

  task automatic cyc(input logic r, input logic [4:0] op, input logic v, input logic s,
                     input logic f, input logic irq, input string tag);
    @(posedge clk);
    #1;
    rst = r; instr_op = op; instr_valid = v; stall = s; flush = f; interrupt_req = irq;
    model_step(tag);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      total++;
      if (op_out !== e.op || fetch_hold !== e.hold || int_ack !== e.ack || busy !== e.busy) begin
        bad++;
        $display("FAIL %s t=%0t: got op=%b hold=%b ack=%b busy=%b, want op=%b hold=%b ack=%b busy=%b",
                 e.tag, $time, op_out, fetch_hold, int_ack, busy, e.op, e.hold, e.ack, e.busy);
      end
    end
  end

  initial begin
    rst = 1'b0; instr_op = 5'b11000; instr_valid = 1'b1;
    stall = 1'b0; flush = 1'b0; interrupt_req = 1'b0;
    m_pend = 1'b0;

    // Reset with a CALL sitting in IF/ID, then release.
    cyc(0, 5'b11000, 1, 0, 0, 0, "reset0");
    cyc(0, 5'b11000, 1, 0, 0, 0, "reset1");
    cyc(1, 5'b11000, 1, 0, 0, 0, "rst_rel_call");
    cyc(1, ADD, 1, 0, 0, 0, "call_second");
    cyc(1, ADD, 1, 0, 0, 0, "after_call");

    // Interrupt during ADD stream.
    cyc(1, ADD, 1, 0, 0, 1, "int_c0");
    cyc(1, ADD, 1, 0, 0, 0, "int_c1");
    cyc(1, ADD, 1, 0, 0, 0, "int_c2");
    cyc(1, ADD, 1, 0, 0, 0, "int_c3");
    cyc(1, ADD, 1, 0, 0, 0, "int_c4");

    // Interrupt during RET.
    cyc(1, 5'b11010, 1, 0, 0, 1, "ret_int0");
    cyc(1, ADD, 1, 0, 0, 0, "ret_int1");
    repeat (3) cyc(1, ADD, 1, 0, 0, 0, "ret_int_seq");

    // Stall inside RTI.
    cyc(1, 5'b11100, 1, 0, 0, 0, "rti0");
    cyc(1, ADD, 1, 1, 0, 0, "rti_stall1");
    cyc(1, ADD, 1, 1, 0, 0, "rti_stall2");
    cyc(1, ADD, 1, 0, 0, 0, "rti_second");

    // Illegal fetched opcode and invalid slot.
    cyc(1, 5'b11111, 1, 0, 0, 0, "illegal");
    cyc(1, ADD, 0, 0, 0, 0, "invalid");

    // Flush in SECOND discards the second part.
    cyc(1, 5'b11000, 1, 0, 0, 0, "flush_call");
    cyc(1, ADD, 1, 0, 1, 0, "flush_second");
    cyc(1, ADD, 1, 0, 0, 0, "after_flush");

    // Flush in INT1 is ignored.
    cyc(1, ADD, 1, 0, 0, 1, "fint0");
    cyc(1, ADD, 1, 0, 0, 0, "fint1");
    cyc(1, ADD, 1, 0, 1, 0, "fint_flush");
    cyc(1, ADD, 1, 0, 0, 0, "fint_bubble");

    // Reset mid-sequence aborts the second part.
    cyc(1, 5'b11000, 1, 0, 0, 0, "abort_call");
    cyc(0, ADD, 1, 0, 0, 0, "abort_rst");
    cyc(1, ADD, 1, 0, 0, 0, "abort_after");

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] op;
      logic       r, s, f, q, v;
      op = ($urandom_range(0, 2) == 0) ? 5'b11000 + 5'($urandom_range(0, 7))
                                       : 5'($urandom);
      v = ($urandom_range(0, 9) != 0);
      r = ($urandom_range(0, 99) != 0);
      s = ($urandom_range(0, 4) == 0);
      f = ($urandom_range(0, 9) == 0);
      q = ($urandom_range(0, 14) == 0);
      cyc(r, op, v, s, f, q, "random");
    end

    repeat (3) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d unchecked entries, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/opcode_sequencer.md
# opcode_sequencer

Sits between the IF/ID register and the control unit in decode, and produces the 5-bit opcode the control unit consumes each cycle. Fetched instructions pass through unchanged. CALL, RET and RTI are expanded into their two-part opcode pairs. Interrupt pseudo-opcode pairs are injected at instruction boundaries. The block freezes fetch while a second part is pending, so the control unit never sees a partial sequence.

## Interface
- `INT_OP1`, default 5'b11110: first interrupt pseudo-opcode.
- `INT_OP2`, default 5'b11111: second interrupt pseudo-opcode.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `instr_op`  in  5  opcode field of the instruction in IF/ID.
- `instr_valid`  in  1  IF/ID holds a real instruction.
- `stall`  in  1  hazard-unit stall; freezes the sequencer.
- `flush`  in  1  squash the instruction in decode (branch taken downstream).
- `interrupt_req`  in  1  external interrupt request, sampled every cycle.
- `op_out`  out  5  opcode to control unit.
- `fetch_hold`  out  1  hold PC and IF/ID this cycle.
- `int_ack`  out  1  one-cycle pulse when the second interrupt opcode issues.
- `busy`  out  1  state is not IDLE.

## Operation
- States: IDLE, SECOND, INT1, INT2.
- Pending flag `pend`:
  - Set on any cycle with `interrupt_req`=1.
  - Cleared on entry to INT1.
  - Multiple requests while pending merge into one.
- IDLE, `pend`=1, no stall, no flush:
  - `op_out`=INT_OP1, `fetch_hold`=1, next state INT1.
  - Interrupt takes priority over the fetched instruction, which is left in IF/ID.
- IDLE, `instr_valid`=1, `instr_op` in {11000, 11010, 11100}:
  - `op_out`=`instr_op`, `fetch_hold`=1, next state SECOND.
  - Store `instr_op`|5'b00001 as the second opcode.
- IDLE, any other valid opcode: `op_out`=`instr_op`, `fetch_hold`=0.
- Fetched opcodes 11001, 11011, 11101, 11110 and 11111 are illegal from fetch. Replace with 00000.
- `instr_valid`=0 gives `op_out`=00000.
- SECOND: `op_out`=stored opcode, `fetch_hold`=0, next state IDLE.
- INT1: `op_out`=INT_OP2, `fetch_hold`=1, `int_ack`=1, next state INT2.
- INT2: `op_out`=00000 (drain bubble), `fetch_hold`=0, next state IDLE.
- `stall`=1:
  - `op_out`=00000 and `fetch_hold`=0.
  - State and stored opcode are frozen; `pend` still sets.
- `flush`=1 in IDLE or SECOND:
  - `op_out`=00000, `fetch_hold`=0, next state IDLE.
  - A pending second part is discarded.
- `flush` is ignored in INT1 and INT2; an interrupt sequence always completes.
- Priority: `rst` > `flush` > `stall` > normal.

## Timing
- Reset (`rst`=0 at a rising edge):
  - State becomes IDLE; `pend` and the stored opcode are cleared.
  - While `rst`=0, outputs are forced to `op_out`=00000, `fetch_hold`=0, `int_ack`=0, `busy`=0.
- `op_out` and `fetch_hold` are combinational from state, `pend` and inputs. Zero latency for passthrough.
- Two-part instructions take 2 consecutive unstalled cycles, with one fetch-hold cycle.
- Interrupt request at edge N sets `pend`. Earliest INT_OP1 issues in cycle N+1 if the sequencer is IDLE; otherwise on the first IDLE cycle after SECOND.
- The full interrupt sequence is INT_OP1, INT_OP2, bubble. `int_ack` is high exactly in the INT_OP2 cycle.
- `busy`=1 in SECOND, INT1 and INT2.
- `rst`=0 mid-sequence aborts immediately. No second part issues after release.
- A request arriving in the same cycle that `pend` clears re-sets `pend`, so a second interrupt follows.

## Test plan
- Reset: `rst`=0 for 2 cycles with `instr_op`=11000 and `instr_valid`=1 -> `op_out`=00000, `fetch_hold`=0, `busy`=0. First cycle after release -> `op_out`=11000.
- CALL: 11000 valid then 01001 -> `op_out` sequence 11000 (`fetch_hold`=1), 11001 (`fetch_hold`=0), 01001.
- Interrupt: `interrupt_req` pulse in cycle 0 during an ADD stream -> cycle 1: 11110 with `fetch_hold`=1; cycle 2: 11111 with `int_ack`=1; cycle 3: 00000; cycle 4: ADD 01001.
- Interrupt during RET: request in the 11010 cycle -> 11010, 11011, 11110, 11111, 00000.
- Stall in the middle of RTI: 11100, then `stall`=1 for 2 cycles, then release -> 11100, 00000, 00000, 11101.
- Illegal opcode and flush:
  - Fetched 11111 -> `op_out`=00000.
  - 11000 followed by `flush`=1 in SECOND -> `op_out`=00000, state IDLE, no 11001 ever issued.
  - `flush`=1 in INT1 -> 11111 still issues.
